// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, opcodes, operand-select encodings and the
// registered bundle layout. The execute-stage ALU imports this package as well.
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluSlt  = 4'b1000,
    AluSltu = 4'b1001,
    AluLui  = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [1:0] SrcARs1  = 2'b00;
  localparam logic [1:0] SrcAPc   = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;
  localparam logic       SrcBRs2  = 1'b0;
  localparam logic       SrcBImm  = 1'b1;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu;
    logic [1:0]  src_a;
    logic        src_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
  } dec_bundle_t;

  // funct3 mapping shared by register and immediate ALU forms (funct7 variants excluded)
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate format from the opcode
// and returns it sign-extended (U-type pre-shifted, shift-immediates as a 5-bit shamt).
module alu_imm_gen
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm = 32'h0;
    case (opcode)
      OpcImm: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm = {27'h0, instr[24:20]};
        end else begin
          imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OpcLoad, OpcJalr: imm = {{20{instr[31]}}, instr[31:20]};
      OpcStore:         imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OpcBranch: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OpcLui, OpcAuipc: imm = {instr[31:12], 12'h0};
      OpcJal: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:          imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage feeding the execute ALU over valid/ready.
// ALU_DEC_ILLEGAL_EN: when defined, bad encodings are flagged via illegal instead of hidden.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [1:0]  src_a_sel,
  output logic        src_b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal,
  output logic [31:0] pc_out
);

  logic        out_valid_q;
  dec_bundle_t bundle_q, bundle_d;
  logic [31:0] imm_gen;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        accept, writes, bad;
  alu_op_e     alu_d;
  logic [1:0]  src_a_d;
  logic        src_b_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  alu_imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm_gen)
  );

  always_comb begin
    alu_d   = AluAdd;
    src_a_d = SrcARs1;
    src_b_d = SrcBImm;
    writes  = 1'b0;
    bad     = 1'b0;
    case (opcode)
      OpcReg: begin
        src_b_d = SrcBRs2;
        writes  = 1'b1;
        alu_d   = base_op(funct3);
        if (funct7 == Funct7Alt && funct3 == 3'b000) begin
          alu_d = AluSub;
        end else if (funct7 == Funct7Alt && funct3 == 3'b101) begin
          alu_d = AluSra;
        end else if (funct7 != Funct7Zero) begin
          bad = 1'b1;
        end
      end
      OpcImm: begin
        writes = 1'b1;
        alu_d  = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != Funct7Zero) bad = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == Funct7Alt) alu_d = AluSra;
          else if (funct7 != Funct7Zero) bad = 1'b1;
        end
      end
      // LUI ignores its rs1 field, so feed a zero operand
      OpcLui: begin
        alu_d   = AluLui;
        src_a_d = SrcAZero;
        writes  = 1'b1;
      end
      OpcAuipc: begin
        src_a_d = SrcAPc;
        writes  = 1'b1;
      end
      OpcLoad: begin
        writes = 1'b1;
        bad    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OpcStore: bad = funct3[2] || (funct3 == 3'b011);
      OpcBranch: begin
        src_b_d = SrcBRs2;
        bad     = (funct3[2:1] == 2'b01);
        if (!funct3[2])     alu_d = AluSub;
        else if (funct3[1]) alu_d = AluSltu;
        else                alu_d = AluSlt;
      end
      OpcJal: begin
        src_a_d = SrcAPc;
        writes  = 1'b1;
      end
      OpcJalr: begin
        writes = 1'b1;
        bad    = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase

    bundle_d.alu       = alu_d;
    bundle_d.src_a     = src_a_d;
    bundle_d.src_b     = src_b_d;
    bundle_d.imm       = imm_gen;
    bundle_d.rs1       = instr[19:15];
    bundle_d.rs2       = instr[24:20];
    bundle_d.rd        = instr[11:7];
    bundle_d.reg_write = writes && (instr[11:7] != 5'd0);
    bundle_d.pc        = pc;
    // Bad encodings become an ADD of zero with no writeback
    if (bad) begin
      bundle_d.alu       = AluAdd;
      bundle_d.src_a     = SrcAZero;
      bundle_d.src_b     = SrcBImm;
      bundle_d.imm       = 32'h0;
      bundle_d.reg_write = 1'b0;
    end
`ifdef ALU_DEC_ILLEGAL_EN
    bundle_d.illegal = bad;
`else
    bundle_d.illegal = 1'b0;
`endif
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      bundle_q    <= bundle_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = bundle_q.alu;
  assign src_a_sel   = bundle_q.src_a;
  assign src_b_sel   = bundle_q.src_b;
  assign imm         = bundle_q.imm;
  assign rs1         = bundle_q.rs1;
  assign rs2         = bundle_q.rs2;
  assign rd          = bundle_q.rd;
  assign reg_write   = bundle_q.reg_write;
  assign illegal     = bundle_q.illegal;
  assign pc_out      = bundle_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: driver pushes model results, monitor pops on handshake.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  sa;
    logic        sb;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    logic [31:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, imm, pc_out;
  logic [3:0]  alu_control;
  logic [1:0]  src_a_sel;
  logic        src_b_sel, reg_write, illegal;
  logic [4:0]  rs1, rs2, rd;

  int n_total = 0;
  int n_bad   = 0;
  bundle_t q[$];
  bit pushed_now = 1'b0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .src_a_sel   (src_a_sel),
    .src_b_sel   (src_b_sel),
    .imm         (imm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .pc_out      (pc_out)
  );

  // Reference decode written from the instruction-set rules
  function automatic bundle_t model(input logic [31:0] w, input logic [31:0] p);
    bundle_t     b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [3:0]  op_tab [8];
    bit          ok, writes;
    op_tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = w[14:12];
    f7 = w[31:25];
    i_imm = {{20{w[31]}}, w[31:20]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    b = '0;
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    b.rd  = w[11:7];
    b.pc  = p;
    b.sb  = 1'b1;
    ok = 1'b1;
    writes = 1'b0;
    case (w[6:0])
      7'h33: begin
        b.sb = 1'b0;
        writes = 1'b1;
        b.alu = op_tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) b.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) b.alu = 4'd7;
        else if (f7 != 7'h00) ok = 1'b0;
      end
      7'h13: begin
        writes = 1'b1;
        b.alu = op_tab[f3];
        b.imm = i_imm;
        if (f3 == 3'd1 || f3 == 3'd5) b.imm = 32'(w[24:20]);
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) b.alu = 4'd7;
        else if (f3 == 3'd5 && f7 != 7'h00) ok = 1'b0;
      end
      7'h37: begin b.alu = 4'd10; b.sa = 2'd2; b.imm = w & 32'hFFFFF000; writes = 1'b1; end
      7'h17: begin b.sa = 2'd1; b.imm = w & 32'hFFFFF000; writes = 1'b1; end
      7'h03: begin ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); b.imm = i_imm; writes = 1'b1; end
      7'h23: begin ok = (f3 <= 3'd2); b.imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
      7'h63: begin
        b.sb = 1'b0;
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        b.alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
        b.imm = {{19{b13[12]}}, b13};
      end
      7'h6f: begin b.sa = 2'd1; b.imm = {{11{j21[20]}}, j21}; writes = 1'b1; end
      7'h67: begin ok = (f3 == 3'd0); b.imm = i_imm; writes = 1'b1; end
      default: ok = 1'b0;
    endcase
    b.wr = writes && (w[11:7] != 5'd0);
    if (!ok) begin
      b.alu = 4'd0;
      b.sa  = 2'd2;
      b.sb  = 1'b1;
      b.imm = 32'h0;
      b.wr  = 1'b0;
`ifdef ALU_DEC_ILLEGAL_EN
      b.ill = 1'b1;
`endif
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9];
    logic [31:0] w;
    int unsigned r, s;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 9) w[6:0] = opcs[r];
    s = $urandom_range(0, 3);
    if (s < 2) w[31:25] = 7'h00;
    else if (s == 2) w[31:25] = 7'h20;
    return w;
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                       input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    instr     = w;
    pc        = $urandom;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    pushed_now = 1'b0;
    if (in_valid && in_ready && !flush && !rst) begin
      q.push_back(model(instr, pc));
      pushed_now = 1'b1;
    end
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if ({out_valid, alu_control, src_a_sel, src_b_sel, imm, rs1, rs2, rd, reg_write, illegal,
         pc_out} !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs not cleared, got alu=%h imm=%h pc_out=%h valid=%b", name,
               alu_control, imm, pc_out, out_valid);
    end
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: in_ready got %b want 1", name, in_ready);
    end
  endtask

  bundle_t got, exp_b;
  bit      ev;

  always @(negedge clk) begin : mon
    ev = (q.size() > (pushed_now ? 1 : 0));
    n_total++;
    if (out_valid !== ev) begin
      n_bad++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, ev, $time);
    end
    n_total++;
    if (in_ready !== (!ev || out_ready)) begin
      n_bad++;
      $display("FAIL in_ready: got %b want %b at %0t", in_ready, !ev || out_ready, $time);
    end
    if (out_valid && out_ready && !flush && !rst && q.size() > 0) begin
      exp_b = q.pop_front();
      got = {alu_control, src_a_sel, src_b_sel, imm, rs1, rs2, rd, reg_write, illegal, pc_out};
      n_total++;
      if (got !== exp_b) begin
        n_bad++;
        $display("FAIL bundle: got alu=%h sa=%h sb=%b imm=%h rs=%0d/%0d rd=%0d wr=%b ill=%b pc=%h want alu=%h sa=%h sb=%b imm=%h rs=%0d/%0d rd=%0d wr=%b ill=%b pc=%h",
                 got.alu, got.sa, got.sb, got.imm, got.rs1, got.rs2, got.rd, got.wr, got.ill,
                 got.pc, exp_b.alu, exp_b.sa, exp_b.sb, exp_b.imm, exp_b.rs1, exp_b.rs2,
                 exp_b.rd, exp_b.wr, exp_b.ill, exp_b.pc);
      end
    end
    if (flush || rst) q.delete();
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0);
    check_zero("reset_state");

    // sub, srai, lui, all-zero word back to back
    drive(1, 32'h402081B3, 1, 0, 0);
    drive(1, 32'h40335293, 1, 0, 0);
    drive(1, 32'h123450B7, 1, 0, 0);
    drive(1, 32'h00000000, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);

    // Backpressure, then drain and accept together
    drive(1, 32'h402081B3, 0, 0, 0);
    repeat (3) drive(1, 32'h40335293, 0, 0, 0);
    drive(1, 32'h123450B7, 1, 0, 0);
    drive(0, 32'h0, 1, 0, 0);

    // Flush drops a same-cycle accept
    drive(1, 32'h402081B3, 0, 1, 0);
    drive(0, 32'h0, 1, 0, 0);

    // Reset while stalled
    drive(1, 32'h402081B3, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 0);
    check_zero("reset_mid_stall");

    for (int i = 0; i < 600; i++) begin
      bit iv, ordy, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      if (fl) ordy = 1'b0;
      drive(iv, rand_instr(), ordy, fl, 0);
    end

    repeat (4) drive(0, 32'h0, 1, 0, 0);
    n_total++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d bundles never delivered, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
